// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: loadable program memory, PC stepper and halt/stall control feeding the decoder.
// Define FETCH_STEP_EN to add single-step fetch control (i_StepMode / i_Step).
module instruction_fetch_unit #(
    parameter int          ADDR_W    = 6,
    parameter int          DEPTH     = 64,
    parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
    input  logic              i_CLK,
    input  logic              i_RST,
    input  logic              i_LoadEn,
    input  logic [ADDR_W-1:0] i_LoadAddr,
    input  logic [15:0]       i_LoadData,
    input  logic              i_Start,
    input  logic              i_Stall,
`ifdef FETCH_STEP_EN
    input  logic              i_StepMode,
    input  logic              i_Step,
`endif
    output logic [15:0]       o_Instr,
    output logic              o_InstrValid,
    output logic [ADDR_W-1:0] o_PC,
    output logic              o_Running,
    output logic              o_Halted
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [15:0]       r_mem [0:DEPTH-1];
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [15:0]       r_instr;
    logic [15:0]       w_instr_nxt;
    logic              r_valid;
    logic              w_valid_nxt;
    logic              r_running;
    logic              r_halted;
    logic              w_load;
    logic              w_fetch_en;
    logic [15:0]       w_word;

    assign w_word = r_mem[r_pc];

    // Decide whether this edge may fetch: stall always wins, step mode gates further.
`ifdef FETCH_STEP_EN
    assign w_fetch_en = !i_Stall && (!i_StepMode || i_Step);
`else
    assign w_fetch_en = !i_Stall;
`endif

    // Next-state, next-PC and next-output decode.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
        w_valid_nxt = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE, ST_HALT: begin
                // A load in the same cycle as start wins; start is dropped.
                if (i_LoadEn) begin
                    w_load = 1'b1;
                end else if (i_Start) begin
                    w_state_nxt = ST_RUN;
                    w_pc_nxt    = {ADDR_W{1'b0}};
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_RUN: begin
                if (!w_fetch_en) begin
                    w_valid_nxt = 1'b0;
                end else if (w_word == HALT_WORD) begin
                    w_state_nxt = ST_HALT;
                end else begin
                    w_instr_nxt = w_word;
                    w_valid_nxt = 1'b1;
                    w_pc_nxt    = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_pc_nxt    = {ADDR_W{1'b0}};
            end
        endcase
    end

    // State, PC and registered outputs.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_state   <= ST_IDLE;
            r_pc      <= {ADDR_W{1'b0}};
            r_instr   <= 16'h0000;
            r_valid   <= 1'b0;
            r_running <= 1'b0;
            r_halted  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_instr   <= w_instr_nxt;
            r_valid   <= w_valid_nxt;
            r_running <= (w_state_nxt == ST_RUN);
            r_halted  <= (w_state_nxt == ST_HALT);
        end
    end

    // Program memory write port; contents survive reset.
    always_ff @(posedge i_CLK) begin
        if (!i_RST && w_load) begin
            r_mem[i_LoadAddr] <= i_LoadData;
        end
    end

    assign o_Instr      = r_instr;
    assign o_InstrValid = r_valid;
    assign o_PC         = r_pc;
    assign o_Running    = r_running;
    assign o_Halted     = r_halted;

endmodule
